data_mem_responder: RTL and testbench

//  Data-memory slave on the core's load/store port: services Mem_read/Mem_Write from the RISC-V top.

---
 rtl/data_mem_responder_if.sv | 21 ++
 rtl/data_mem_responder.sv | 77 +++++++
 tb/tb_data_mem_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the core and the data-memory responder.
// Master is the core; slave is the memory model.
interface data_mem_responder_if;
   logic        Mem_read;
   logic        Mem_Write;
   logic [31:0] a_data_mem;
   logic [31:0] w_data_mem;
   logic [31:0] r_data_mem;
   logic        stall;
   logic        mem_err;

   modport master (
      output Mem_read, Mem_Write, a_data_mem, w_data_mem,
      input  r_data_mem, stall, mem_err
   );

   modport slave (
      input  Mem_read, Mem_Write, a_data_mem, w_data_mem,
      output r_data_mem, stall, mem_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed per-access wait count.
// Flags misaligned, out-of-range and read+write requests on mem_err.
module data_mem_responder #(
   parameter int          DEPTH   = 256,
   parameter int          ADDR_W  = 8,
   parameter logic [31:0] BASE    = 32'h0000_0000,
   parameter int          LATENCY = 2
) (
   input logic                 clk,
   input logic                 reset,
   data_mem_responder_if.slave bus
);

   localparam logic [3:0]  LAT  = 4'(LATENCY);
   localparam logic [31:0] SPAN = 32'(DEPTH * 4);

   logic [3:0]        cnt_q;
   logic [3:0]        cnt_d;
   logic              req;
   logic              access;
   logic              in_range;
   logic              misal;
   logic              fault;
   logic              both;
   logic              wr_en;
   logic [31:0]       offset;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       mem_q [DEPTH];

   // Decode the request; reset masks it so nothing completes or writes.
   always_comb begin
      req      = (bus.Mem_read | bus.Mem_Write) & reset;
      offset   = bus.a_data_mem - BASE;
      in_range = offset < SPAN;
      misal    = bus.a_data_mem[1:0] != 2'b00;
      idx      = offset[ADDR_W+1:2];
      access   = req & (cnt_q == LAT);
      fault    = ~in_range | misal;
      both     = bus.Mem_read & bus.Mem_Write;
      wr_en    = access & bus.Mem_Write & ~fault;
   end

   // Bus outputs: stall until the counter reaches LAT, data only on completion.
   always_comb begin
      bus.stall      = req & (cnt_q != LAT);
      bus.mem_err    = access & (fault | both);
      bus.r_data_mem = '0;
      if (access & bus.Mem_read & ~bus.Mem_Write & ~fault)
         bus.r_data_mem = mem_q[idx];
   end

   // Wait counter: count up while stalled, clear on commit or dropped request.
   always_comb begin
      cnt_d = cnt_q;
      if (!req)
         cnt_d = '0;
      else if (access)
         cnt_d = '0;
      else
         cnt_d = cnt_q + 4'd1;
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // RAM array; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[idx] <= bus.w_data_mem;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder at LATENCY=2 and LATENCY=0.
// Stimulus pushes expected completions; monitors pop and compare.
module tb_data_mem_responder;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;

   logic [32:0] q2 [$];
   logic [32:0] q0 [$];
   logic [32:0] e2;
   logic [32:0] e0;

   data_mem_responder_if bus2 ();
   data_mem_responder_if bus0 ();

   data_mem_responder #(.LATENCY(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   data_mem_responder #(.LATENCY(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor for the LATENCY=2 instance
   always @(negedge clk) begin
      if (reset) begin
         if ((bus2.Mem_read | bus2.Mem_Write) && !bus2.stall) begin
            if (q2.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL l2_unexpected: completion with empty queue at %0t", $time);
            end else begin
               e2 = q2.pop_front();
               chk("l2_rdata", bus2.r_data_mem, e2[32:1]);
               chk("l2_err", {31'b0, bus2.mem_err}, {31'b0, e2[0]});
            end
         end else begin
            chk("l2_idle_rdata", bus2.r_data_mem, 32'h0);
            chk("l2_idle_err", {31'b0, bus2.mem_err}, 32'h0);
         end
      end
   end

   // Monitor for the LATENCY=0 instance
   always @(negedge clk) begin
      if (reset) begin
         if ((bus0.Mem_read | bus0.Mem_Write) && !bus0.stall) begin
            if (q0.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL l0_unexpected: completion with empty queue at %0t", $time);
            end else begin
               e0 = q0.pop_front();
               chk("l0_rdata", bus0.r_data_mem, e0[32:1]);
               chk("l0_err", {31'b0, bus0.mem_err}, {31'b0, e0[0]});
            end
         end else begin
            chk("l0_idle_stall", {31'b0, bus0.stall}, 32'h0);
         end
      end
   end

   task automatic drive2(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
      bus2.Mem_read   = rd;
      bus2.Mem_Write  = wr;
      bus2.a_data_mem = a;
      bus2.w_data_mem = d;
   endtask

   task automatic drive0(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
      bus0.Mem_read   = rd;
      bus0.Mem_Write  = wr;
      bus0.a_data_mem = a;
      bus0.w_data_mem = d;
   endtask

   // One full access on the LATENCY=2 bus: stall 1,1 then complete.
   task automatic acc2(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee);
      q2.push_back({er, ee});
      @(posedge clk);
      #1;
      drive2(rd, wr, a, d);
      repeat (2) begin
         @(negedge clk);
         chk("l2_stall_wait", {31'b0, bus2.stall}, 32'd1);
      end
      @(negedge clk);
      chk("l2_stall_done", {31'b0, bus2.stall}, 32'd0);
      @(posedge clk);
      #1;
      drive2(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // One access on the LATENCY=0 bus, left driven for back-to-back use.
   task automatic acc0(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee);
      q0.push_back({er, ee});
      @(posedge clk);
      #1;
      drive0(rd, wr, a, d);
      @(negedge clk);
      chk("l0_stall", {31'b0, bus0.stall}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b0;
      drive2(1'b1, 1'b0, 32'h10, 32'h0);
      drive0(1'b0, 1'b0, 32'h0, 32'h0);
      #3;
      chk("rst_stall", {31'b0, bus2.stall}, 32'd0);
      chk("rst_rdata", bus2.r_data_mem, 32'h0);
      chk("rst_err", {31'b0, bus2.mem_err}, 32'h0);
      drive2(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // write then read back with two wait cycles each
      acc2(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
      acc2(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

      // zero-wait back-to-back write then read
      acc0(1'b0, 1'b1, 32'h4, 32'h0000_1234, 32'h0, 1'b0);
      acc0(1'b1, 1'b0, 32'h4, 32'h0, 32'h0000_1234, 1'b0);
      acc0(1'b0, 1'b1, 32'h10, 32'h0000_0777, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      drive0(1'b0, 1'b0, 32'h0, 32'h0);

      // faults: misaligned and out of range, reads and suppressed writes
      acc2(1'b0, 1'b1, 32'h4, 32'h1111_2222, 32'h0, 1'b0);
      acc2(1'b1, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1);
      acc2(1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
      acc2(1'b0, 1'b1, 32'h6, 32'hFFFF_FFFF, 32'h0, 1'b1);
      acc2(1'b0, 1'b1, 32'h404, 32'h0000_0BAD, 32'h0, 1'b1);
      acc2(1'b1, 1'b0, 32'h4, 32'h0, 32'h1111_2222, 1'b0);

      // read and write together: error, write still lands
      acc2(1'b1, 1'b1, 32'h8, 32'hA5A5_A5A5, 32'h0, 1'b1);
      acc2(1'b1, 1'b0, 32'h8, 32'h0, 32'hA5A5_A5A5, 1'b0);

      // reset pulse in the middle of a wait
      acc2(1'b0, 1'b1, 32'hC, 32'h0, 32'h0, 1'b0);
      q2.push_back({32'h0, 1'b0});
      @(posedge clk);
      #1;
      drive2(1'b0, 1'b1, 32'hC, 32'h55);
      @(negedge clk);
      chk("rw_stall_pre", {31'b0, bus2.stall}, 32'd1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      drive0(1'b0, 1'b1, 32'h10, 32'h0000_0BAD);
      #1;
      chk("rw_stall_in_reset", {31'b0, bus2.stall}, 32'd0);
      chk("rw_rdata_in_reset", bus2.r_data_mem, 32'h0);
      chk("rw_err_in_reset", {31'b0, bus0.mem_err}, 32'h0);
      @(posedge clk);
      #1;
      drive0(1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rw_stall_after", {31'b0, bus2.stall}, 32'd1);
      end
      @(negedge clk);
      chk("rw_stall_commit", {31'b0, bus2.stall}, 32'd0);
      @(posedge clk);
      #1;
      drive2(1'b0, 1'b0, 32'h0, 32'h0);
      acc2(1'b1, 1'b0, 32'hC, 32'h0, 32'h0000_0055, 1'b0);
      acc0(1'b1, 1'b0, 32'h10, 32'h0, 32'h0000_0777, 1'b0);
      @(posedge clk);
      #1;
      drive0(1'b0, 1'b0, 32'h0, 32'h0);

      // request dropped after one wait cycle, then reissued
      @(posedge clk);
      #1;
      drive2(1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      chk("drop_stall_first", {31'b0, bus2.stall}, 32'd1);
      @(posedge clk);
      #1;
      drive2(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("drop_stall_idle", {31'b0, bus2.stall}, 32'd0);
      acc2(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

      repeat (2) @(posedge clk);
      chk("q2_drained", 32'(q2.size()), 32'd0);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
